sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO with independent write and read enables.
//  All DEPTH entries are usable, and read and write can complete in the same cycle.
//  Provides an occupancy count, programmable almost-full/almost-empty flags,
//  and sticky overflow/underflow error flags.
//  Serves as the general buffering element between producer/consumer stages in one clock domain.
// PARAMETERS
//  WIDTH        8    data width in bits (>=1)
//  DEPTH        16   number of entries; power of two, >=2
//  AFULL_LVL    12   almost_full asserts when count >= AFULL_LVL (1..DEPTH)
//  AEMPTY_LVL   4    almost_empty asserts when count <= AEMPTY_LVL (0..DEPTH-1)
// PORTS
//  clk           in   1                 rising-edge clock
//  rst           in   1                 synchronous reset, active high
//  wr_en         in   1                 write request
//  data_in       in   WIDTH             write data
//  rd_en         in   1                 read request
//  data_out      out  WIDTH             read data, registered
//  rd_valid      out  1                 data_out holds newly read word this cycle
//  full          out  1                 count == DEPTH
//  empty         out  1                 count == 0
//  almost_full   out  1                 count >= AFULL_LVL
//  almost_empty  out  1                 count <= AEMPTY_LVL
//  count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  overflow      out  1                 sticky: write rejected while full
//  underflow     out  1                 sticky: read rejected while empty
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - w_ptr=r_ptr=0, count=0, data_out=0, rd_valid=0, overflow=underflow=0.
//   - Memory contents are not reset.
//   - After reset: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_LVL>=1).
//   - Reset has priority over all requests. Any in-flight data is discarded.
//  Pointers:
//   - log2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
//   - count tracks occupancy separately.
//  Acceptance, evaluated on state before the edge:
//   - wr_ok = wr_en && (!full || rd_ok)
//   - rd_ok = rd_en && !empty
//  Write: on wr_ok, mem[w_ptr] <= data_in and w_ptr++.
//  Read:
//   - On rd_ok, data_out <= mem[r_ptr], r_ptr++, rd_valid <= 1.
//   - Otherwise rd_valid <= 0 and data_out holds.
//   - Latency: data is visible one cycle after the rd_en edge.
//  count update:
//   - +1 on wr_ok only; -1 on rd_ok only.
//   - Unchanged when both or neither are accepted.
//  Simultaneous wr_en and rd_en:
//   - Full: both accepted; count stays DEPTH; the read returns the oldest word.
//   - Empty: write accepted, read rejected (no fall-through).
//     count becomes 1 and underflow sets.
//   - Otherwise: both accepted.
//  Error flags:
//   - overflow <= 1 when wr_en && !wr_ok.
//   - underflow <= 1 when rd_en && !rd_ok.
//   - Both hold until rst. A rejected request changes no other state.
//  Flag timing:
//   - full/empty/almost_* are combinational from count, so they update in the cycle after the accepting edge.
//  Ordering: strict FIFO order across pointer wrap-around.
// TESTING (WIDTH=8, DEPTH=16, AFULL_LVL=12, AEMPTY_LVL=4)
//  1. Reset, then 16 writes 0x00..0x0F
//     -> count 1..16; almost_full at count 12; full at 16; overflow stays 0.
//  2. 17th write 0xAA while full
//     -> rejected; count=16; overflow=1 (sticky);
//        then 16 reads return 0x00..0x0F, each 1 cycle after rd_en, with rd_valid=1.
//  3. Read while empty
//     -> rd_valid=0; data_out holds last value; underflow=1; count=0.
//  4. Full FIFO, wr_en=rd_en=1 for 20 cycles with incrementing data
//     -> count stays 16; output order is continuous through pointer wrap; no overflow.
//  5. Empty FIFO, wr_en=rd_en=1 with 0x55
//     -> count=1, rd_valid=0, underflow=1; next cycle a read returns 0x55.
//  6. Fill 8 entries, assert rst for one cycle mid-stream
//     -> next cycle count=0, empty=1, data_out=0, flags cleared;
//        the next write/read pair returns the new data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky overflow/underflow.
// Read data is registered, one cycle after an accepted rd_en; a write is still accepted while full when a read frees a slot.
module sync_fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    w_ptr_q, w_ptr_d;
    logic [AW-1:0]    r_ptr_q, r_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q  | (wr_en && !wr_ok);
        underflow_d = underflow_q | (rd_en && !rd_ok);
        if (wr_ok) begin
            w_ptr_d = w_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            r_ptr_d    = r_ptr_q + AW'(1);
            data_out_d = mem_q[r_ptr_q];
            rd_valid_d = 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[w_ptr_q] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: read data checked by a monitor against a scoreboard queue,
// occupancy and flags checked against hand-computed values after each edge.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .AFULL_LVL(12), .AEMPTY_LVL(4)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-data monitor: every rd_valid must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got data %0h with no read pending at %0t", data_out, $time);
            end else begin
                chk("rd_data", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus; the scoreboard learns which read will be honoured.
    task automatic step(input logic wr, input logic [7:0] din, input logic rd);
        bit rd_ok, wr_ok;
        rd_ok = rd && (mdl.size() > 0);
        wr_ok = wr && ((mdl.size() < 16) || rd_ok);
        if (rd_ok) exp_q.push_back(mdl.pop_front());
        if (wr_ok) mdl.push_back(din);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},    count, 0);
        chk({tag, "_empty"},    empty, 1);
        chk({tag, "_full"},     full, 0);
        chk({tag, "_aempty"},   almost_empty, 1);
        chk({tag, "_afull"},    almost_full, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        do_reset();
        do_reset();
        chk_reset_state("rst");

        // Fill 0x00..0x0F, watching flags at every level.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_count", count, i + 1);
            chk("fill_afull", almost_full, (i + 1) >= 12);
            chk("fill_aempty", almost_empty, (i + 1) <= 4);
            chk("fill_full", full, (i + 1) == 16);
            chk("fill_overflow", overflow, 0);
        end

        // Write while full is rejected and sets the sticky overflow.
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_count", count, 15 - i);
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_overflow", overflow, 1);
        end
        chk("drain_empty", empty, 1);

        // Read while empty.
        step(1'b0, 8'h00, 1'b1);
        chk("unf_rd_valid", rd_valid, 0);
        chk("unf_data_hold", data_out, 8'h0F);
        chk("unf_flag", underflow, 1);
        chk("unf_count", count, 0);

        // Full FIFO with simultaneous write/read across the pointer wrap.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        chk("rw_full_start", full, 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h20 + 8'(i), 1'b1);
            chk("rw_full_count", count, 16);
            chk("rw_full_overflow", overflow, 0);
            chk("rw_full_rd_valid", rd_valid, 1);
        end
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        chk("rw_drain_empty", empty, 1);

        // Simultaneous write/read on empty: no fall-through.
        step(1'b1, 8'h55, 1'b1);
        chk("e_rw_count", count, 1);
        chk("e_rw_rd_valid", rd_valid, 0);
        chk("e_rw_underflow", underflow, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("e_rw_read_valid", rd_valid, 1);
        chk("e_rw_read_data", data_out, 8'h55);

        // Reset in the middle of a partial fill.
        for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        chk("mid_count", count, 8);
        do_reset();
        chk_reset_state("mid_rst");
        step(1'b1, 8'h77, 1'b0);
        chk("post_rst_count", count, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_rd_data", data_out, 8'h77);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
